adder_serial: RTL and testbench



---
 rtl/adder_serial_pkg.sv | 13 +
 rtl/adder_full.sv | 14 +
 rtl/adder_serial.sv | 98 +++++++++
 tb/tb_adder_serial.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_serial_pkg.sv
// Shared constants for the bit-serial LSB-first adder.
// State encoding and counter sizing used by adder_serial.
package adder_serial_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/adder_full.sv
// One-bit full adder cell, purely combinational.
// Port order mirrors the team's one-bit full subtractor.
module adder_full (
  input  logic a,
  input  logic b,
  input  logic incarry,
  output logic sum,
  output logic outcarry
);

  assign sum      = a ^ b ^ incarry;
  assign outcarry = (a & b) | (a & incarry) | (b & incarry);

endmodule

// File: rtl/adder_serial.sv
// Bit-serial LSB-first W-bit adder with valid/ready in and out.
// One full-adder cell is reused for every bit position.
module adder_serial
  import adder_serial_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] augend,
  input  logic [W-1:0] addend,
  input  logic         incarry,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         outcarry,
  output logic         overflow
);

  localparam int CW = cnt_width(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [1:0]    r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_sum;
  logic          r_carry;
  logic          r_ovf;
  logic [CW-1:0] r_cnt;

  logic w_bit;
  logic w_cout;
  logic w_last;
  logic w_accept;

  adder_full u_cell (
    .a        (r_a[0]),
    .b        (r_b[0]),
    .incarry  (r_carry),
    .sum      (w_bit),
    .outcarry (w_cout)
  );

  assign w_last    = (r_cnt == LAST);
  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = (r_state == DONE);
  assign w_accept  = in_valid && in_ready;

  assign sum      = r_sum;
  assign outcarry = r_carry;
  assign overflow = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      unique case (r_state)
        IDLE: if (w_accept) r_state <= RUN;
        RUN:  if (w_last) r_state <= DONE;
        DONE: if (out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Carry flop doubles as outcarry once the last bit is done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == IDLE) begin
      if (w_accept) begin
        r_a     <= augend;
        r_b     <= addend;
        r_carry <= incarry;
        r_cnt   <= '0;
      end
    end else if (r_state == RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_sum   <= (r_sum >> 1) | (W'(w_bit) << (W - 1));
      r_carry <= w_cout;
      if (w_last) begin
        r_cnt <= '0;
        r_ovf <= r_carry ^ w_cout;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_adder_serial.sv
// Self-checking bench for adder_serial (W=8).
// Directed literal cases plus randomized traffic against a model.
module tb_adder_serial;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] augend = '0;
  logic [W-1:0] addend = '0;
  logic         incarry = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         outcarry;
  logic         overflow;

  int errors = 0;
  int checks = 0;

  adder_serial #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .augend    (augend),
    .addend    (addend),
    .incarry   (incarry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .outcarry  (outcarry),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic [W:0] s);
    return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  // Model: result known at acceptance, visible W edges later.
  logic       m_idle = 1'b1;
  logic       m_done = 1'b0;
  int         m_left = 0;
  logic [W:0] m_res  = '0;
  logic       m_ovf  = 1'b0;
  int         n_ops  = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idle <= 1'b1;
      m_done <= 1'b0;
      m_left <= 0;
      m_res  <= '0;
      m_ovf  <= 1'b0;
    end else if (m_idle) begin
      if (in_valid) begin
        m_res  <= ref_add(augend, addend, incarry);
        m_ovf  <= ref_ovf(augend, addend,
                          ref_add(augend, addend, incarry));
        m_left <= W;
        m_idle <= 1'b0;
      end
    end else if (!m_done) begin
      m_left <= m_left - 1;
      if (m_left == 1) m_done <= 1'b1;
    end else if (out_ready) begin
      m_done <= 1'b0;
      m_idle <= 1'b1;
      n_ops  <= n_ops + 1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_outcarry", outcarry, 0);
      chk("rst_overflow", overflow, 0);
    end else begin
      chk("in_ready", in_ready, m_idle);
      chk("out_valid", out_valid, m_done);
      if (m_done) begin
        chk("sum", sum, m_res[W-1:0]);
        chk("outcarry", outcarry, m_res[W]);
        chk("overflow", overflow, m_ovf);
      end
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input int hold, input bit noise,
                       input logic [W-1:0] es, input logic eco,
                       input logic eov, input string nm);
    int n;
    @(negedge clk);
    augend = a;
    addend = b;
    incarry = c;
    in_valid = 1'b1;
    out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_accept"}, in_ready, 1);
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      if (noise) begin
        in_valid = 1'($urandom);
        augend = W'($urandom);
        addend = W'($urandom);
        incarry = 1'($urandom);
      end else begin
        in_valid = 1'b0;
        augend = ~a;
        addend = ~b;
      end
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 40);
    chk({nm, "_latency"}, n, W);
    chk({nm, "_sum"}, sum, es);
    chk({nm, "_cout"}, outcarry, eco);
    chk({nm, "_ovf"}, overflow, eov);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < hold; i++) begin
      chk({nm, "_hold_valid"}, out_valid, 1);
      chk({nm, "_hold_sum"}, sum, es);
      chk({nm, "_hold_cout"}, outcarry, eco);
      chk({nm, "_hold_ready"}, in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_idle_ready"}, in_ready, 1);
    chk({nm, "_idle_valid"}, out_valid, 0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("init_in_ready", in_ready, 0);
    chk("init_out_valid", out_valid, 0);
    chk("init_sum", sum, 0);
    chk("init_outcarry", outcarry, 0);
    chk("init_overflow", overflow, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);

    do_op(8'h00, 8'h00, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0, "zero");
    do_op(8'hFF, 8'h01, 1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b0, "ff_1");
    do_op(8'h7F, 8'h01, 1'b0, 0, 1'b0, 8'h80, 1'b0, 1'b1, "7f_1");
    do_op(8'hA5, 8'h5A, 1'b1, 0, 1'b0, 8'h00, 1'b1, 1'b0, "a5_5a");
    do_op(8'h80, 8'h80, 1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b1, "80_80");
    do_op(8'h3C, 8'h0F, 1'b0, 5, 1'b0, 8'h4B, 1'b0, 1'b0, "bp");
    do_op(8'h9D, 8'h6E, 1'b1, 1, 1'b1, 8'h0C, 1'b1, 1'b0, "noise");

    // Abort 0x12+0x34 during its fourth RUN cycle.
    @(negedge clk);
    augend = 8'h12;
    addend = 8'h34;
    incarry = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_sum", sum, 0);
    chk("abort_ready", in_ready, 0);
    chk("abort_cout", outcarry, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    do_op(8'h12, 8'h34, 1'b0, 0, 1'b0, 8'h46, 1'b0, 1'b0, "after_rst");

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      augend = W'($urandom);
      addend = W'($urandom);
      incarry = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (W + 4) @(negedge clk);
    chk("random_ops_done", (n_ops >= 100) ? 1 : 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
